// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmit line between two
// byte requesters (valid/ready). One byte is granted per frame.
// Ports: clk, reset (async, active-high)
//   req0_data/req0_valid/req0_ready : requester 0 byte handshake
//   req1_data/req1_valid/req1_ready : requester 1 byte handshake
//   TxD      : registered serial output, idle high
//   isBusy   : frame in progress (state != IDLE)
//   grant_id : requester owning the current or most recent frame
//   tx_done  : one-cycle pulse when the stop bit completes
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic       TxD,
    output logic       isBusy,
    output logic       grant_id,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    logic idle;
    logic wrap;
    logic gnt0;
    logic gnt1;

    assign idle = (state_q == IDLE);
    assign wrap = (cnt_q == CNT_MAX);

    // Ready is gated by reset so it drops asynchronously with the reset.
    // On a tie the requester that did not own the last frame wins.
    assign gnt0 = ~reset & idle & req0_valid & (~req1_valid | last_q);
    assign gnt1 = ~reset & idle & req1_valid & (~req0_valid | ~last_q);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign TxD      = txd_q;
    assign isBusy   = busy_q;
    assign grant_id = grant_q;
    assign tx_done  = done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        grant_d   = grant_q;
        last_d    = last_q;
        done_d    = 1'b0;
        txd_d     = 1'b1;

        if (state_q != IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (gnt0 | gnt1) begin
                    shift_d = gnt1 ? req1_data : req0_data;
                    grant_d = gnt1;
                    last_d  = gnt1;
                    state_d = START;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (wrap) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (wrap) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level follows the current state one cycle later.
        unique case (state_q)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with CLKS_PER_BIT=4.
// Frames and grants are predicted from the 8N1 and round-robin rules.
module tb_uart_tx_arbiter;

    localparam int CPB    = 4;
    localparam int PERIOD = 10 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_ready;
    logic       TxD;
    logic       isBusy;
    logic       grant_id;
    logic       tx_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int model_last  = 1;
    logic done_prev = 1'b0;

    uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .TxD        (TxD),
        .isBusy     (isBusy),
        .grant_id   (grant_id),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Continuous protocol properties, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            vectors++;
            if (req0_ready && req1_ready) begin
                miscompares++;
                $display("FAIL ready_onehot t=%0t r0=%b r1=%b want not both",
                         $time, req0_ready, req1_ready);
            end
            vectors++;
            if ((req0_ready || req1_ready) && isBusy) begin
                miscompares++;
                $display("FAIL ready_idle t=%0t busy=%b ready seen, want none",
                         $time, isBusy);
            end
            vectors++;
            if (!isBusy && TxD !== 1'b1) begin
                miscompares++;
                $display("FAIL txd_idle t=%0t TxD=%b want 1", $time, TxD);
            end
            vectors++;
            if (tx_done && done_prev) begin
                miscompares++;
                $display("FAIL done_width t=%0t tx_done high 2 cycles, want 1",
                         $time);
            end
        end
        done_prev <= tx_done;
    end

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b0;
        model_last = 1;
    endtask

    // Returns the requester that handshook, the edge number of the
    // handshake and the byte on its data bus in that cycle. Ends #1
    // after the handshake edge; id=-1 if the budget runs out.
    task automatic wait_hs(output int id, output int at,
                           output logic [7:0] dat);
        bit hit;
        id  = -1;
        at  = -1;
        dat = 8'h00;
        hit = 1'b0;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (req0_valid && req0_ready) begin
                id  = 0;
                dat = req0_data;
                hit = 1'b1;
            end else if (req1_valid && req1_ready) begin
                id  = 1;
                dat = req1_data;
                hit = 1'b1;
            end
            @(posedge clk);
            #1;
            if (hit) begin
                at = cyc;
                break;
            end
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL hs_timeout no handshake in 200 cycles");
        end
    endtask

    // Called #1 after a handshake edge; samples each bit mid-window
    // and finishes #1 after the edge where tx_done should rise.
    task automatic capture_frame(output logic pre, output logic [9:0] bits,
                                 output logic done, output logic gid);
        pre = TxD;
        gid = grant_id;
        bits = '0;
        repeat (2) tick();
        for (int k = 0; k < 10; k++) begin
            bits[k] = TxD;
            if (k < 9) repeat (CPB) tick();
        end
        repeat (2) tick();
        done = tx_done;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h3C;
        req1_data  = 8'hC3;
        #3;
        vectors++;
        if ({TxD, isBusy, grant_id, tx_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_out TxD/busy/id/done=%b want 1000",
                     {TxD, isBusy, grant_id, tx_done});
        end
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 00",
                     {req0_ready, req1_ready});
        end
        apply_reset();
    endtask

    task automatic test_single();
        int id, at;
        logic [7:0] d;
        logic pre, done, gid;
        logic [9:0] bits;
        apply_reset();
        req0_data  = 8'hA5;
        req0_valid = 1'b1;
        wait_hs(id, at, d);
        vectors++;
        if (id != 0) begin
            miscompares++;
            $display("FAIL single_id got %0d want 0", id);
        end
        vectors++;
        if (req0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ready_once got %b want 0", req0_ready);
        end
        req0_valid = 1'b0;
        req0_data  = 8'($urandom);
        capture_frame(pre, bits, done, gid);
        vectors++;
        if (pre !== 1'b1) begin
            miscompares++;
            $display("FAIL single_txd_lag got %b want 1", pre);
        end
        vectors++;
        if (bits !== 10'b1_1010_0101_0) begin
            miscompares++;
            $display("FAIL single_frame got %b want %b", bits,
                     10'b1_1010_0101_0);
        end
        vectors++;
        if (done !== 1'b1 || gid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_id done=%b id=%b want 1 0", done, gid);
        end
        tick();
        vectors++;
        if (tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_clear got %b want 0", tx_done);
        end
    endtask

    task automatic test_alternate();
        int id, at, prev_at, exp_id;
        logic [7:0] d;
        logic pre, done, gid;
        logic [9:0] bits;
        apply_reset();
        req0_data  = 8'h11;
        req1_data  = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        prev_at    = 0;
        for (int i = 0; i < 3; i++) begin
            exp_id     = 1 - model_last;
            model_last = exp_id;
            wait_hs(id, at, d);
            vectors++;
            if (id != exp_id || d !== (exp_id == 1 ? 8'h22 : 8'h11)) begin
                miscompares++;
                $display("FAIL alt_grant%0d id=%0d d=%h want id=%0d", i, id,
                         d, exp_id);
            end
            if (i > 0) begin
                vectors++;
                if (at - prev_at != PERIOD) begin
                    miscompares++;
                    $display("FAIL alt_period%0d got %0d want %0d", i,
                             at - prev_at, PERIOD);
                end
            end
            prev_at = at;
            capture_frame(pre, bits, done, gid);
            vectors++;
            if (bits !== frame_of(exp_id == 1 ? 8'h22 : 8'h11) ||
                done !== 1'b1 || gid !== 1'(exp_id)) begin
                miscompares++;
                $display("FAIL alt_frame%0d bits=%b done=%b id=%b", i, bits,
                         done, gid);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_lone_req1();
        int id, at, prev_at;
        logic [7:0] d, exp_d;
        logic pre, done, gid;
        logic [9:0] bits;
        apply_reset();
        req1_valid = 1'b1;
        prev_at    = 0;
        for (int i = 0; i < 3; i++) begin
            exp_d     = 8'($urandom);
            req1_data = exp_d;
            wait_hs(id, at, d);
            req1_data = 8'($urandom);
            vectors++;
            if (id != 1) begin
                miscompares++;
                $display("FAIL lone_id%0d got %0d want 1", i, id);
            end
            if (i > 0) begin
                vectors++;
                if (at - prev_at != PERIOD) begin
                    miscompares++;
                    $display("FAIL lone_period%0d got %0d want %0d", i,
                             at - prev_at, PERIOD);
                end
            end
            prev_at = at;
            capture_frame(pre, bits, done, gid);
            vectors++;
            if (bits !== frame_of(exp_d) || done !== 1'b1 || gid !== 1'b1)
            begin
                miscompares++;
                $display("FAIL lone_frame%0d bits=%b want %b done=%b id=%b",
                         i, bits, frame_of(exp_d), done, gid);
            end
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int id, at;
        logic [7:0] d, d0, d1;
        logic pre, done, gid;
        logic [9:0] bits;
        apply_reset();
        d0         = 8'($urandom);
        req0_data  = d0;
        req0_valid = 1'b1;
        wait_hs(id, at, d);
        req0_valid = 1'b0;
        req0_data  = 8'($urandom);
        repeat (17) tick();
        vectors++;
        if (TxD !== d0[3]) begin
            miscompares++;
            $display("FAIL mid_bit3 got %b want %b", TxD, d0[3]);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        reset      = 1'b1;
        #1;
        vectors++;
        if ({TxD, isBusy, req0_ready, req1_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_reset TxD/busy/r0/r1=%b want 1000",
                     {TxD, isBusy, req0_ready, req1_ready});
        end
        repeat (2) tick();
        reset      = 1'b0;
        model_last = 1;
        d0         = 8'($urandom);
        d1         = 8'($urandom);
        req0_data  = d0;
        req1_data  = d1;
        wait_hs(id, at, d);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        vectors++;
        if (id != 0) begin
            miscompares++;
            $display("FAIL mid_tie got %0d want 0", id);
        end
        capture_frame(pre, bits, done, gid);
        vectors++;
        if (bits !== frame_of(d0) || done !== 1'b1 || gid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_frame bits=%b want %b done=%b id=%b", bits,
                     frame_of(d0), done, gid);
        end
    endtask

    task automatic test_drop_valid();
        int id, at, seen;
        logic [7:0] d;
        apply_reset();
        req1_data  = 8'h5A;
        req1_valid = 1'b1;
        wait_hs(id, at, d);
        req1_valid = 1'b0;
        repeat (5) tick();
        req0_data  = 8'h77;
        req0_valid = 1'b1;
        repeat (10) tick();
        req0_valid = 1'b0;
        repeat (25) tick();
        vectors++;
        if (tx_done !== 1'b1 || grant_id !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_done done=%b id=%b want 1 1", tx_done,
                     grant_id);
        end
        seen = 0;
        repeat (60) begin
            tick();
            if (isBusy || req0_ready || req1_ready || !TxD) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL drop_extra_frame activity=%0d want 0", seen);
        end
    endtask

    task automatic test_random();
        int id, at, exp_id;
        logic [1:0] v;
        logic [7:0] d, d0, d1, exp_d;
        logic pre, done, gid;
        logic [9:0] bits;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            v = 2'($urandom_range(0, 3));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            req0_data = d0;
            req1_data = d1;
            if (v == 2'b00) begin
                repeat (5) tick();
                vectors++;
                if (isBusy !== 1'b0 || TxD !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rnd_idle%0d busy=%b TxD=%b want 0 1", i,
                             isBusy, TxD);
                end
                continue;
            end
            exp_id     = (v == 2'b11) ? 1 - model_last : (v[1] ? 1 : 0);
            model_last = exp_id;
            exp_d      = (exp_id == 1) ? d1 : d0;
            req0_valid = v[0];
            req1_valid = v[1];
            wait_hs(id, at, d);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            req0_data  = 8'($urandom);
            req1_data  = 8'($urandom);
            vectors++;
            if (id != exp_id) begin
                miscompares++;
                $display("FAIL rnd_grant%0d got %0d want %0d", i, id, exp_id);
            end
            capture_frame(pre, bits, done, gid);
            vectors++;
            if (bits !== frame_of(exp_d) || done !== 1'b1 ||
                gid !== 1'(exp_id)) begin
                miscompares++;
                $display("FAIL rnd_frame%0d bits=%b want %b done=%b id=%b",
                         i, bits, frame_of(exp_d), done, gid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lone_req1();
        test_reset_mid();
        test_drop_valid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
